// File: rtl/axis_kernel_shell.sv
// AXI-stream shell around a generated kernel: input skid buffer, FWFT output FIFO,
// and a start/length controller that counts beats, marks m_tlast and pulses done.
module axis_kernel_shell #(
   parameter int NIN    = 4,
   parameter int NOUT   = 4,
   parameter int CHW    = 64,
   parameter int FDEPTH = 16,
   parameter int CNTW   = 32
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  start,
   input  logic [CNTW-1:0]       cfg_nbeats,
   output logic                  busy,
   output logic                  done,
   input  logic                  s_tvalid,
   input  logic [NIN*CHW-1:0]    s_tdata,
   output logic                  s_tready,
   output logic                  k_ivalid,
   output logic [NIN*CHW-1:0]    k_idata,
   input  logic                  k_iready,
   input  logic                  k_ovalid,
   input  logic [NOUT*CHW-1:0]   k_odata,
   output logic                  k_oready,
   output logic                  m_tvalid,
   output logic [NOUT*CHW-1:0]   m_tdata,
   output logic                  m_tlast,
   input  logic                  m_tready,
   output logic                  err_ovf
);

   // state  | meaning
   // S_IDLE | waiting for start; input closed, kernel output blocked
   // S_RUN  | transaction active; counting s, kernel and m beats
   typedef enum logic {S_IDLE, S_RUN} state_t;

   localparam int IW = NIN * CHW;
   localparam int OW = NOUT * CHW;
   localparam int AW = $clog2(FDEPTH);
   localparam logic [AW:0] LVL_HI = (AW+1)'(FDEPTH - 2);

   state_t            state_q, state_d;
   logic [CNTW-1:0]   nbeats_q, nbeats_d;
   logic [CNTW-1:0]   in_cnt_q, in_cnt_d;
   logic [CNTW-1:0]   out_cnt_q, out_cnt_d;
   logic [CNTW-1:0]   wr_cnt_q, wr_cnt_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic              s_tready_q, s_tready_d;
   logic              main_valid_q, main_valid_d;
   logic [IW-1:0]     main_data_q, main_data_d;
   logic              skid_valid_q, skid_valid_d;
   logic [IW-1:0]     skid_data_q, skid_data_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic [OW-1:0]     mem_q [FDEPTH];

   logic run, s_hs, k_in_hs, k_oready_int, k_out_hs, fifo_wr, ovf;
   logic fifo_nempty, m_hs, last_beat, start_go, start_zero;

   always_comb begin
      run          = (state_q == S_RUN);
      s_hs         = s_tvalid && s_tready_q;
      k_in_hs      = main_valid_q && k_iready;
      k_oready_int = run && (count_q <= LVL_HI);
      k_out_hs     = k_ovalid && k_oready_int;
      fifo_wr      = k_out_hs && (wr_cnt_q < nbeats_q);
      ovf          = k_out_hs && !(wr_cnt_q < nbeats_q);
      fifo_nempty  = (count_q != '0);
      m_hs         = fifo_nempty && m_tready;
      last_beat    = (out_cnt_q == nbeats_q - CNTW'(1));
      start_go     = !run && start && (cfg_nbeats != '0);
      start_zero   = !run && start && (cfg_nbeats == '0);
   end

   always_ff @(posedge aclk) begin
      if (areset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_go) state_d = S_RUN;
         S_RUN:   if (m_hs && last_beat) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = run;
      done     = done_q;
      err_ovf  = err_q;
      s_tready = s_tready_q;
      k_ivalid = main_valid_q;
      k_idata  = main_data_q;
      k_oready = k_oready_int;
      m_tvalid = fifo_nempty;
      m_tdata  = fifo_nempty ? mem_q[rd_ptr_q] : '0;
      m_tlast  = fifo_nempty && run && last_beat;
   end

   always_comb begin
      nbeats_d  = nbeats_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      err_d     = err_q;
      if (start_go) begin
         nbeats_d  = cfg_nbeats;
         in_cnt_d  = '0;
         out_cnt_d = '0;
         wr_cnt_d  = '0;
         err_d     = 1'b0;
      end else begin
         if (s_hs)         in_cnt_d  = in_cnt_q + CNTW'(1);
         if (m_hs && run)  out_cnt_d = out_cnt_q + CNTW'(1);
         if (fifo_wr)      wr_cnt_d  = wr_cnt_q + CNTW'(1);
         if (ovf)          err_d     = 1'b1;
      end
      done_d = start_zero || (run && m_hs && last_beat);

      // A beat accepted while main is stalled parks in skid; s_tready closes behind it.
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (skid_valid_q) begin
         if (k_in_hs) begin
            main_data_d  = skid_data_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end
      end else if (s_hs) begin
         if (main_valid_q && !k_iready) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_tdata;
         end else begin
            main_valid_d = 1'b1;
            main_data_d  = s_tdata;
         end
      end else if (k_in_hs) begin
         main_valid_d = 1'b0;
      end
      s_tready_d = !skid_valid_d && (state_d == S_RUN) && (in_cnt_d < nbeats_d);

      wr_ptr_d = wr_ptr_q + AW'(fifo_wr);
      rd_ptr_d = rd_ptr_q + AW'(m_hs);
      count_d  = count_q + (AW+1)'(fifo_wr) - (AW+1)'(m_hs);
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         nbeats_q     <= '0;
         in_cnt_q     <= '0;
         out_cnt_q    <= '0;
         wr_cnt_q     <= '0;
         err_q        <= 1'b0;
         done_q       <= 1'b0;
         s_tready_q   <= 1'b0;
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         nbeats_q     <= nbeats_d;
         in_cnt_q     <= in_cnt_d;
         out_cnt_q    <= out_cnt_d;
         wr_cnt_q     <= wr_cnt_d;
         err_q        <= err_d;
         done_q       <= done_d;
         s_tready_q   <= s_tready_d;
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

   // Storage needs no reset: the read side is gated by the occupancy count.
   always_ff @(posedge aclk) begin
      if (fifo_wr) mem_q[wr_ptr_q] <= k_odata;
   end

endmodule
